// File: rtl/axi_wr_arbiter.sv
// rtl/axi_wr_arbiter.sv - two-requester round-robin AXI4 write-channel arbiter
module axi_wr_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    ACLK,
    input  logic                    ARESETn,
    // requester 0
    input  logic [ADDR_WIDTH-1:0]   S0_AWADDR,
    input  logic [7:0]              S0_AWLEN,
    input  logic [2:0]              S0_AWSIZE,
    input  logic [1:0]              S0_AWBURST,
    input  logic                    S0_AWVALID,
    output logic                    S0_AWREADY,
    input  logic [DATA_WIDTH-1:0]   S0_WDATA,
    input  logic [DATA_WIDTH/8-1:0] S0_WSTRB,
    input  logic                    S0_WLAST,
    input  logic                    S0_WVALID,
    output logic                    S0_WREADY,
    output logic [1:0]              S0_BRESP,
    output logic                    S0_BVALID,
    input  logic                    S0_BREADY,
    // requester 1
    input  logic [ADDR_WIDTH-1:0]   S1_AWADDR,
    input  logic [7:0]              S1_AWLEN,
    input  logic [2:0]              S1_AWSIZE,
    input  logic [1:0]              S1_AWBURST,
    input  logic                    S1_AWVALID,
    output logic                    S1_AWREADY,
    input  logic [DATA_WIDTH-1:0]   S1_WDATA,
    input  logic [DATA_WIDTH/8-1:0] S1_WSTRB,
    input  logic                    S1_WLAST,
    input  logic                    S1_WVALID,
    output logic                    S1_WREADY,
    output logic [1:0]              S1_BRESP,
    output logic                    S1_BVALID,
    input  logic                    S1_BREADY,
    // slave side
    output logic [ADDR_WIDTH-1:0]   M_AWADDR,
    output logic [7:0]              M_AWLEN,
    output logic [2:0]              M_AWSIZE,
    output logic [1:0]              M_AWBURST,
    output logic                    M_AWVALID,
    input  logic                    M_AWREADY,
    output logic [DATA_WIDTH-1:0]   M_WDATA,
    output logic [DATA_WIDTH/8-1:0] M_WSTRB,
    output logic                    M_WLAST,
    output logic                    M_WVALID,
    input  logic                    M_WREADY,
    input  logic [1:0]              M_BRESP,
    input  logic                    M_BVALID,
    output logic                    M_BREADY,
    // status
    output logic                    GRANT,
    output logic                    BUSY
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AW   = 2'd1,
        ST_W    = 2'd2,
        ST_B    = 2'd3
    } state_t;

    state_t state_q, state_d;
    logic   grant_q, grant_d;
    logic   last_grant_q, last_grant_d;
    logic   busy_q;

    // Next-state: round-robin pick in IDLE, then follow the granted transaction through AW, W and B
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        case (state_q)
            ST_IDLE: begin
                if (S0_AWVALID && S1_AWVALID) begin
                    grant_d = ~last_grant_q;
                    state_d = ST_AW;
                end else if (S0_AWVALID) begin
                    grant_d = 1'b0;
                    state_d = ST_AW;
                end else if (S1_AWVALID) begin
                    grant_d = 1'b1;
                    state_d = ST_AW;
                end
            end
            ST_AW: begin
                if (M_AWVALID && M_AWREADY) begin
                    state_d = ST_W;
                end
            end
            ST_W: begin
                if (M_WVALID && M_WREADY && M_WLAST) begin
                    state_d = ST_B;
                end
            end
            ST_B: begin
                if (M_BVALID && M_BREADY) begin
                    last_grant_d = grant_q;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM registers; last_grant resets to 1 so requester 0 wins the first tie
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q      <= ST_IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            busy_q       <= (state_d != ST_IDLE);
        end
    end

    // Combinational routing of the active phase only; everything else is held at 0
    always_comb begin
        M_AWADDR   = '0;
        M_AWLEN    = '0;
        M_AWSIZE   = '0;
        M_AWBURST  = '0;
        M_AWVALID  = 1'b0;
        M_WDATA    = '0;
        M_WSTRB    = '0;
        M_WLAST    = 1'b0;
        M_WVALID   = 1'b0;
        M_BREADY   = 1'b0;
        S0_AWREADY = 1'b0;
        S0_WREADY  = 1'b0;
        S0_BVALID  = 1'b0;
        S0_BRESP   = 2'b00;
        S1_AWREADY = 1'b0;
        S1_WREADY  = 1'b0;
        S1_BVALID  = 1'b0;
        S1_BRESP   = 2'b00;
        case (state_q)
            ST_AW: begin
                if (!grant_q) begin
                    M_AWADDR   = S0_AWADDR;
                    M_AWLEN    = S0_AWLEN;
                    M_AWSIZE   = S0_AWSIZE;
                    M_AWBURST  = S0_AWBURST;
                    M_AWVALID  = S0_AWVALID;
                    S0_AWREADY = M_AWREADY;
                end else begin
                    M_AWADDR   = S1_AWADDR;
                    M_AWLEN    = S1_AWLEN;
                    M_AWSIZE   = S1_AWSIZE;
                    M_AWBURST  = S1_AWBURST;
                    M_AWVALID  = S1_AWVALID;
                    S1_AWREADY = M_AWREADY;
                end
            end
            ST_W: begin
                if (!grant_q) begin
                    M_WDATA   = S0_WDATA;
                    M_WSTRB   = S0_WSTRB;
                    M_WLAST   = S0_WLAST;
                    M_WVALID  = S0_WVALID;
                    S0_WREADY = M_WREADY;
                end else begin
                    M_WDATA   = S1_WDATA;
                    M_WSTRB   = S1_WSTRB;
                    M_WLAST   = S1_WLAST;
                    M_WVALID  = S1_WVALID;
                    S1_WREADY = M_WREADY;
                end
            end
            ST_B: begin
                if (!grant_q) begin
                    S0_BVALID = M_BVALID;
                    S0_BRESP  = M_BRESP;
                    M_BREADY  = S0_BREADY;
                end else begin
                    S1_BVALID = M_BVALID;
                    S1_BRESP  = M_BRESP;
                    M_BREADY  = S1_BREADY;
                end
            end
            default: ;
        endcase
    end

    assign GRANT = grant_q;
    assign BUSY  = busy_q;

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// tb/tb_axi_wr_arbiter.sv - randomized self-checking bench for axi_wr_arbiter
module tb_axi_wr_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NCYC = 3000;

    logic ACLK = 1'b0;
    logic ARESETn = 1'b0;
    always #5 ACLK = ~ACLK;

    // requester-side signals, indexed by requester
    logic [AW-1:0] s_awaddr [2];
    logic [7:0]    s_awlen  [2];
    logic [2:0]    s_awsize [2];
    logic [1:0]    s_awburst[2];
    logic          s_awvalid[2];
    logic          s_awready[2];
    logic [DW-1:0] s_wdata  [2];
    logic [3:0]    s_wstrb  [2];
    logic          s_wlast  [2];
    logic          s_wvalid [2];
    logic          s_wready [2];
    logic [1:0]    s_bresp  [2];
    logic          s_bvalid [2];
    logic          s_bready [2];

    logic [AW-1:0] M_AWADDR;
    logic [7:0]    M_AWLEN;
    logic [2:0]    M_AWSIZE;
    logic [1:0]    M_AWBURST;
    logic          M_AWVALID, M_AWREADY;
    logic [DW-1:0] M_WDATA;
    logic [3:0]    M_WSTRB;
    logic          M_WLAST, M_WVALID, M_WREADY;
    logic [1:0]    M_BRESP;
    logic          M_BVALID, M_BREADY;
    logic          GRANT, BUSY;

    axi_wr_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .S0_AWADDR(s_awaddr[0]), .S0_AWLEN(s_awlen[0]), .S0_AWSIZE(s_awsize[0]),
        .S0_AWBURST(s_awburst[0]), .S0_AWVALID(s_awvalid[0]), .S0_AWREADY(s_awready[0]),
        .S0_WDATA(s_wdata[0]), .S0_WSTRB(s_wstrb[0]), .S0_WLAST(s_wlast[0]),
        .S0_WVALID(s_wvalid[0]), .S0_WREADY(s_wready[0]),
        .S0_BRESP(s_bresp[0]), .S0_BVALID(s_bvalid[0]), .S0_BREADY(s_bready[0]),
        .S1_AWADDR(s_awaddr[1]), .S1_AWLEN(s_awlen[1]), .S1_AWSIZE(s_awsize[1]),
        .S1_AWBURST(s_awburst[1]), .S1_AWVALID(s_awvalid[1]), .S1_AWREADY(s_awready[1]),
        .S1_WDATA(s_wdata[1]), .S1_WSTRB(s_wstrb[1]), .S1_WLAST(s_wlast[1]),
        .S1_WVALID(s_wvalid[1]), .S1_WREADY(s_wready[1]),
        .S1_BRESP(s_bresp[1]), .S1_BVALID(s_bvalid[1]), .S1_BREADY(s_bready[1]),
        .M_AWADDR(M_AWADDR), .M_AWLEN(M_AWLEN), .M_AWSIZE(M_AWSIZE), .M_AWBURST(M_AWBURST),
        .M_AWVALID(M_AWVALID), .M_AWREADY(M_AWREADY),
        .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB), .M_WLAST(M_WLAST), .M_WVALID(M_WVALID),
        .M_WREADY(M_WREADY),
        .M_BRESP(M_BRESP), .M_BVALID(M_BVALID), .M_BREADY(M_BREADY),
        .GRANT(GRANT), .BUSY(BUSY)
    );

    logic [127:0] all_outs;
    assign all_outs = {31'd0,
        s_awready[0], s_wready[0], s_bvalid[0], s_bresp[0],
        s_awready[1], s_wready[1], s_bvalid[1], s_bresp[1],
        M_AWADDR, M_AWLEN, M_AWSIZE, M_AWBURST, M_AWVALID,
        M_WDATA, M_WSTRB, M_WLAST, M_WVALID, M_BREADY, GRANT, BUSY};

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // requester transaction records
    int            st   [2];
    int            beat [2];
    logic [AW-1:0] t_addr[2];
    logic [7:0]    t_len [2];
    logic [3:0]    t_strb[2];
    logic [DW-1:0] t_data[2][4];

    // slave behaviour
    int         sl_st, sl_cnt;
    logic [1:0] sl_bresp;

    // reference model of the arbitration
    logic mdl_idle, mdl_last, exp_grant, chk_lat;
    int   mbeat, b_done, grants0, grants1;
    logic rst_done;

    // handshakes seen at the sample point, consumed after the next edge
    logic hs_aw[2], hs_w[2], hs_b[2];
    logic hs_mw_last, hs_mb;

    task automatic gen_txn(input int r);
        t_addr[r] = $urandom & 32'hFFFF_FFFC;
        t_len[r]  = 8'($urandom_range(0, 3));
        t_strb[r] = 4'($urandom);
        for (int i = 0; i < 4; i++) t_data[r][i] = $urandom;
    endtask

    task automatic out_req(input int r);
        s_awaddr[r]  = t_addr[r];
        s_awlen[r]   = t_len[r];
        s_awsize[r]  = 3'd2;
        s_awburst[r] = 2'd1;
        s_awvalid[r] = (st[r] == 1);
        s_wdata[r]   = t_data[r][beat[r]];
        s_wstrb[r]   = t_strb[r];
        s_wlast[r]   = (beat[r] == int'(t_len[r]));
        s_wvalid[r]  = (st[r] == 2) && ($urandom_range(0, 3) != 0);
        s_bready[r]  = (st[r] == 3) && ($urandom_range(0, 1) != 0);
    endtask

    task automatic upd_req(input int r);
        if (st[r] == 1 && hs_aw[r]) begin
            st[r] = 2;
            beat[r] = 0;
        end else if (st[r] == 2 && hs_w[r]) begin
            if (beat[r] == int'(t_len[r])) st[r] = 3;
            else beat[r]++;
        end else if (st[r] == 3 && hs_b[r]) begin
            st[r] = 0;
        end
        if (st[r] == 0 && $urandom_range(0, 2) == 0) begin
            gen_txn(r);
            beat[r] = 0;
            st[r] = 1;
        end
    endtask

    task automatic drive_slave();
        M_AWREADY = ($urandom_range(0, 2) != 0);
        M_WREADY  = ($urandom_range(0, 1) != 0);
        if (sl_st == 0 && hs_mw_last) begin
            sl_st    = 1;
            sl_cnt   = $urandom_range(0, 3);
            sl_bresp = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b00;
        end else if (sl_st == 1) begin
            if (sl_cnt == 0) sl_st = 2;
            else sl_cnt--;
        end else if (sl_st == 2 && hs_mb) begin
            sl_st = 0;
        end
        M_BVALID = (sl_st == 2);
        M_BRESP  = (sl_st == 2) ? sl_bresp : 2'b00;
    endtask

    task automatic reset_bench();
        for (int r = 0; r < 2; r++) begin
            st[r] = 0; beat[r] = 0;
            gen_txn(r);
            hs_aw[r] = 0; hs_w[r] = 0; hs_b[r] = 0;
            out_req(r);
        end
        sl_st = 0; sl_cnt = 0; sl_bresp = 2'b00;
        hs_mw_last = 0; hs_mb = 0;
        M_AWREADY = 0; M_WREADY = 0; M_BVALID = 0; M_BRESP = 2'b00;
        mdl_idle = 1; mdl_last = 1; exp_grant = 0; chk_lat = 0; mbeat = 0;
    endtask

    // observe one cycle just before its rising edge and compare with the model
    task automatic sample_and_check();
        int g, o;
        g = int'(exp_grant);
        o = 1 - g;
        for (int r = 0; r < 2; r++) begin
            hs_aw[r] = s_awvalid[r] && s_awready[r];
            hs_w[r]  = s_wvalid[r] && s_wready[r];
            hs_b[r]  = s_bvalid[r] && s_bready[r];
        end
        hs_mw_last = M_WVALID && M_WREADY && M_WLAST;
        hs_mb      = M_BVALID && M_BREADY;

        check_eq("grant", GRANT, exp_grant);
        if (mdl_idle) begin
            check_eq("idle_zero", all_outs & ~128'd2, 128'd0);
        end else begin
            check_eq("busy", BUSY, 1'b1);
            check_eq("other_zero", {s_awready[o], s_wready[o], s_bvalid[o], s_bresp[o]}, 5'd0);
        end
        if (chk_lat) begin
            check_eq("aw_latency", M_AWVALID, 1'b1);
            chk_lat = 0;
        end
        if (M_AWVALID && M_AWREADY) begin
            check_eq("aw_payload", {M_AWADDR, M_AWLEN, M_AWSIZE, M_AWBURST},
                     {t_addr[g], t_len[g], 3'd2, 2'd1});
            mbeat = 0;
        end
        if (M_WVALID && M_WREADY) begin
            if (mbeat > 3) begin
                check_eq("w_extra_beat", 1'b1, 1'b0);
            end else begin
                check_eq("w_beat", {M_WDATA, M_WSTRB, M_WLAST},
                         {t_data[g][mbeat], t_strb[g], (mbeat == int'(t_len[g]))});
            end
            mbeat++;
        end
        if (mdl_idle && (s_awvalid[0] || s_awvalid[1])) begin
            if (s_awvalid[0] && s_awvalid[1]) exp_grant = ~mdl_last;
            else exp_grant = s_awvalid[1];
            if (exp_grant) grants1++;
            else grants0++;
            mdl_idle = 0;
            chk_lat  = 1;
        end else if (!mdl_idle && s_bvalid[g] && s_bready[g]) begin
            check_eq("bresp", s_bresp[g], sl_bresp);
            mdl_last = exp_grant;
            mdl_idle = 1;
            b_done++;
        end
    endtask

    initial begin
        b_done = 0; grants0 = 0; grants1 = 0; rst_done = 0;
        reset_bench();
        repeat (3) @(negedge ACLK);
        check_eq("reset_outs", all_outs, 128'd0);
        check_eq("reset_grant_busy", {GRANT, BUSY}, 2'b00);
        @(posedge ACLK); #1;
        ARESETn = 1'b1;
        // both requesters ask together straight out of reset: requester 0 must win
        gen_txn(0); gen_txn(1);
        st[0] = 1; st[1] = 1;
        out_req(0); out_req(1);
        drive_slave();

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge ACLK);
            sample_and_check();
            @(posedge ACLK); #1;
            if (!rst_done && cyc > 1200 &&
                ((st[0] == 2 && beat[0] >= 1) || (st[1] == 2 && beat[1] >= 1))) begin
                ARESETn = 1'b0;
                #1;
                check_eq("mid_reset_outs", all_outs, 128'd0);
                reset_bench();
                repeat (2) @(posedge ACLK);
                #1;
                ARESETn = 1'b1;
                rst_done = 1;
                gen_txn(1);
                st[1] = 1;
                out_req(1);
            end else begin
                upd_req(0);
                upd_req(1);
                out_req(0);
                out_req(1);
                drive_slave();
            end
        end

        check_eq("mid_reset_hit", rst_done, 1'b1);
        check_eq("progress", (b_done >= 40), 1'b1);
        check_eq("both_served", (grants0 >= 10 && grants1 >= 10), 1'b1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_wr_arbiter.md
# axi_wr_arbiter

Two-requester AXI4 write-channel arbiter placed in front of the single-ported `axi_slave` memory. It grants one requester per write transaction using round-robin priority and holds that grant across the AW, W and B phases. It routes the granted requester's channels to the slave and stalls the other requester until the B handshake completes.

## Interface
- ADDR_WIDTH, 32, address width on all AW channels
- DATA_WIDTH, 32, data width; strobe width is DATA_WIDTH/8
- Reset: ARESETn, asynchronous, active-low. Clock: ACLK.
- ACLK  in  1  clock, all logic on rising edge
- ARESETn  in  1  asynchronous active-low reset
- S0_/S1_AWADDR, AWLEN, AWSIZE, AWBURST  in  ADDR_WIDTH/8/3/2  requester AW payload
- S0_/S1_AWVALID  in  1  requester write request
- S0_/S1_AWREADY  out  1  AW accept to requester
- S0_/S1_WDATA, WSTRB, WLAST  in  DATA_WIDTH/DATA_WIDTH/8/1  requester W payload
- S0_/S1_WVALID  in  1  requester write data valid
- S0_/S1_WREADY  out  1  W accept to requester
- S0_/S1_BRESP  out  2  response routed back to requester
- S0_/S1_BVALID  out  1  response valid to requester
- S0_/S1_BREADY  in  1  requester response accept
- M_AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID  out  as above  AW to slave
- M_AWREADY  in  1  slave AW accept
- M_WDATA, WSTRB, WLAST, WVALID  out  as above  W to slave
- M_WREADY  in  1  slave W accept
- M_BRESP  in  2; M_BVALID  in  1; M_BREADY  out  1  B from slave
- GRANT  out  1  index of current/last granted requester
- BUSY  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, AW, W, B. Registers: `state`, `grant`, `last_grant`.
- IDLE: sample S0_AWVALID/S1_AWVALID.
  - One request: grant that requester.
  - Both requesting: grant the index != last_grant.
  - On a grant: register `grant` and go to AW. With no request, stay in IDLE.
- AW: M_AW* payload and M_AWVALID come from requester `grant`; Sg_AWREADY = M_AWREADY. On M_AWVALID && M_AWREADY, go to W.
- W: M_W* come from requester `grant`; Sg_WREADY = M_WREADY. On a handshake with WLAST=1, go to B. Beats with WLAST=0 stay in W.
- B: Sg_BVALID = M_BVALID; Sg_BRESP = M_BRESP; M_BREADY = Sg_BREADY. On the handshake, set last_grant <= grant and go to IDLE.
- Non-granted requester: AWREADY, WREADY and BVALID are held 0 at all times, and its BRESP is 0.
- Channel outputs whose phase is inactive drive 0: M_AWVALID outside AW, M_WVALID outside W, M_BREADY outside B, and all M_ payload outside its phase.
- BRESP is passed through unchanged, including SLVERR (2'b10).
- The arbiter does not count beats. It does not reorder or interleave transactions. At most one transaction is outstanding.

## Timing
- Reset values:
  - state=IDLE, grant=0, last_grant=1, so S0 wins the first tie.
  - Every output is 0: all S*_AWREADY/WREADY/BVALID/BRESP, all M_* outputs, GRANT and BUSY.
- Reset asserted mid-transaction returns immediately to IDLE with all outputs 0. The in-flight transaction is abandoned.
- Arbitration latency: AWVALID sampled high at edge N gives M_AWVALID=1 in cycle N+1.
- Routing within a phase is combinational, with zero added latency. The READY/VALID loops pass straight through.
- Turnaround: a B handshake at edge k puts the FSM in IDLE at k+1. The next M_AWVALID is asserted no earlier than cycle k+2.
- AWVALID from a requester while it is not granted is held pending; the AXI rule that VALID stays high applies. It is never dropped.
- A requester that drops AWVALID before the grant edge is not granted.
- GRANT updates on the IDLE->AW edge and holds until the next grant.

## Test plan
- Single S0 write: AWADDR=0x10, AWLEN=3, INCR, 4 beats with WLAST on beat 4 -> 4 M_W handshakes; S0_BVALID with BRESP=00; S1 never sees a READY.
- Simultaneous requests from reset: S0 and S1 both assert AWVALID in the same cycle -> S0 granted first, S1 second; GRANT sequence 0,1.
- Fairness: both requesters continuously requesting 6 single-beat transactions -> grants alternate 0,1,0,1,0,1.
- Back-pressure: M_AWREADY low for 3 cycles and M_WREADY toggling -> no beat lost or duplicated; S1_AWVALID held high throughout is served after S0's B handshake.
- Error pass-through: slave returns BRESP=2'b10 (early WLAST, AWLEN=3 with WLAST on beat 2) -> requester receives BRESP=10 and the FSM returns to IDLE.
- Reset during W phase, after beat 2 of 4 -> all outputs 0 within the reset; after release, a fresh S1 request is granted normally.
